// File: rtl/dct4_folded_seq_if.sv
// Handshake and data bundle for the folded 4-point DCT even-coefficient block.
// The master side supplies input vectors and drains results; the slave side is the transform.
interface dct4_folded_seq_if #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 24
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a0;
  logic signed [DATA_W-1:0] a1;
  logic signed [DATA_W-1:0] a2;
  logic signed [DATA_W-1:0] a3;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  z0;
  logic signed [OUT_W-1:0]  z2;
  logic signed [OUT_W-1:0]  z4;
  logic signed [OUT_W-1:0]  z6;
  logic                     busy;

  modport master (
    output in_valid, a0, a1, a2, a3, out_ready,
    input  in_ready, out_valid, z0, z2, z4, z6, busy
  );

  modport slave (
    input  in_valid, a0, a1, a2, a3, out_ready,
    output in_ready, out_valid, z0, z2, z4, z6, busy
  );
endinterface

// File: rtl/dct4_folded_seq.sv
// Folded 4-point DCT even-coefficient transform: one signed multiplier and one
// accumulator step through the 4x4 coefficient matrix in 16 MAC cycles per vector.
module dct4_folded_seq #(
  parameter int                        DATA_W = 10,
  parameter int                        COEF_W = 12,
  parameter int                        OUT_W  = DATA_W + COEF_W + 2,
  parameter logic signed [COEF_W-1:0]  C2     = 12'sd1892,
  parameter logic signed [COEF_W-1:0]  C4     = 12'sd1448,
  parameter logic signed [COEF_W-1:0]  C6     = 12'sd783
) (
  input  logic             clk,
  input  logic             rst,
  dct4_folded_seq_if.slave bus
);

  localparam int PROD_W = COEF_W + 1 + DATA_W;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_nx;

  logic        [3:0]        cnt;
  logic        [1:0]        row;
  logic        [1:0]        col;
  logic signed [DATA_W-1:0] smp_p0 [4];
  logic signed [DATA_W-1:0] samp;
  logic signed [OUT_W-1:0]  prod;
  logic signed [OUT_W-1:0]  sum;
  logic signed [OUT_W-1:0]  acc_p1;
  logic signed [OUT_W-1:0]  res0_p1, res1_p1, res2_p1;
  logic signed [OUT_W-1:0]  z0_p2, z2_p2, z4_p2, z6_p2;

  // Coefficients widened by one bit so that negation of any constant is representable.
  function automatic logic signed [COEF_W:0] coef(input logic [1:0] k, input logic [1:0] j);
    logic signed [COEF_W:0] p2, p4, p6;
    logic signed [COEF_W:0] c;
    p2 = {C2[COEF_W-1], C2};
    p4 = {C4[COEF_W-1], C4};
    p6 = {C6[COEF_W-1], C6};
    case ({k, j})
      4'b00_00, 4'b00_01, 4'b00_10, 4'b00_11: c = p4;
      4'b01_00: c = p2;
      4'b01_01: c = p6;
      4'b01_10: c = -p6;
      4'b01_11: c = -p2;
      4'b10_00, 4'b10_11: c = p4;
      4'b10_01, 4'b10_10: c = -p4;
      4'b11_00: c = p6;
      4'b11_01: c = -p2;
      4'b11_10: c = p2;
      default:  c = -p6;
    endcase
    return c;
  endfunction

  function automatic logic signed [OUT_W-1:0] mac_product(input logic signed [COEF_W:0]   c,
                                                          input logic signed [DATA_W-1:0] x);
    logic signed [PROD_W-1:0] p;
    p = c * x;
    return {{(OUT_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  assign row = cnt[3:2];
  assign col = cnt[1:0];

  always_comb begin
    samp = smp_p0[col];
    prod = mac_product(coef(row, col), samp);
    sum  = acc_p1 + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = MAC;
      MAC:     if (cnt == 4'd15)  state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // p0: sample capture; p1: accumulate one row; p2: publish all four rows at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc_p1  <= '0;
      res0_p1 <= '0;
      res1_p1 <= '0;
      res2_p1 <= '0;
      z0_p2   <= '0;
      z2_p2   <= '0;
      z4_p2   <= '0;
      z6_p2   <= '0;
      for (int i = 0; i < 4; i++) smp_p0[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            smp_p0[0] <= bus.a0;
            smp_p0[1] <= bus.a1;
            smp_p0[2] <= bus.a2;
            smp_p0[3] <= bus.a3;
            cnt       <= '0;
          end
        end
        MAC: begin
          cnt <= cnt + 4'd1;
          if (col == 2'd0)      acc_p1 <= prod;
          else if (col != 2'd3) acc_p1 <= sum;
          else begin
            case (row)
              2'd0:    res0_p1 <= sum;
              2'd1:    res1_p1 <= sum;
              2'd2:    res2_p1 <= sum;
              default: ;
            endcase
          end
          // Last row is still in flight, so z6 comes straight from the adder.
          if (cnt == 4'd15) begin
            z0_p2 <= res0_p1;
            z2_p2 <= res1_p1;
            z4_p2 <= res2_p1;
            z6_p2 <= sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == MAC);
  assign bus.out_valid = (state == DONE);
  assign bus.z0        = z0_p2;
  assign bus.z2        = z2_p2;
  assign bus.z4        = z4_p2;
  assign bus.z6        = z6_p2;

endmodule
